// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
//
// Purpose
//   Serialises one byte per accepted write into an asynchronous UART frame:
//   start (0), D0..D7 LSB first, even parity, stop (1). Bit timing comes from
//   an internal sample-tick divider (OVERSAMPLE ticks per bit) driven by the
//   same baud_select table the far-end receiver uses.
//
// Configuration
//   UART_TX_TWO_STOP_EN  when defined, a second stop bit (STOP2) follows STOP
//                        and Tx_BUSY / Tx_DONE move to the end of STOP2.
//                        Undefined (default): single stop bit.
//
// Parameters
//   OVERSAMPLE  sample ticks per bit (bit period = OVERSAMPLE * DIV clocks)
//   DIV_W       width of the clock divider counter
//
// Ports
//   clk          in   system clock (50 MHz)
//   reset        in   asynchronous, active-low reset
//   baud_select  in   [2:0] baud code, latched when a write is accepted
//   Tx_EN        in   transmitter enable; 0 forces IDLE and aborts a frame
//   Tx_WR        in   write strobe (one-cycle pulse)
//   Tx_DATA      in   [7:0] byte to send, latched with Tx_WR
//   TxD          out  serial line, idles high (registered)
//   Tx_BUSY      out  high from the cycle after accept to the end of the frame
//   Tx_DONE      out  one-cycle pulse in the cycle the last stop bit ends
// ---------------------------------------------------------------------------
module uart_transmitter #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    input  logic [7:0] Tx_DATA,
    output logic       TxD,
    output logic       Tx_BUSY,
    output logic       Tx_DONE
);

    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_TX_TWO_STOP_EN
        ,
        S_STOP2
`endif
    } state_t;

    // Clocks per sample tick for each baud code (300 .. 115200 baud at 50 MHz).
    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
        case (sel)
            3'd0:    baud_div = DIV_W'(10417);
            3'd1:    baud_div = DIV_W'(2604);
            3'd2:    baud_div = DIV_W'(651);
            3'd3:    baud_div = DIV_W'(326);
            3'd4:    baud_div = DIV_W'(163);
            3'd5:    baud_div = DIV_W'(81);
            3'd6:    baud_div = DIV_W'(54);
            default: baud_div = DIV_W'(27);
        endcase
    endfunction

    // Registered state
    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic              parity_bit;
    logic [DIV_W-1:0]  div_lat;

    // Next-state values
    state_t            state_n;
    logic [DIV_W-1:0]  div_cnt_n;
    logic [TICK_W-1:0] tick_cnt_n;
    logic [2:0]        bit_idx_n;
    logic [7:0]        shreg_n;
    logic              parity_n;
    logic [DIV_W-1:0]  div_lat_n;
    logic              txd_n;
    logic              done_n;
    logic              tick;
    logic              bit_end;

    // Busy is simply "not idle"; since state is a register this rises in the
    // same cycle TxD falls for the start bit and drops with the Tx_DONE pulse.
    assign Tx_BUSY = (state != S_IDLE);

    // -----------------------------------------------------------------------
    // Next-state / datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves one unassigned, which would infer a latch.
        state_n    = state;
        div_cnt_n  = div_cnt;
        tick_cnt_n = tick_cnt;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        parity_n   = parity_bit;
        div_lat_n  = div_lat;
        done_n     = 1'b0;
        tick       = 1'b0;
        bit_end    = 1'b0;

        if (!Tx_EN) begin
            // Disable aborts any frame in flight; nothing resumes later.
            state_n = S_IDLE;
        end else if (state == S_IDLE) begin
            if (Tx_WR) begin
                state_n   = S_START;
                shreg_n   = Tx_DATA;
                parity_n  = ^Tx_DATA;
                div_lat_n = baud_div(baud_select);
            end
        end else begin
            // Sample-tick divider: counts 0..DIV-1, ticks on the last count.
            if (div_cnt == div_lat - DIV_W'(1)) begin
                div_cnt_n = '0;
                tick      = 1'b1;
            end else begin
                div_cnt_n = div_cnt + DIV_W'(1);
            end

            // A bit ends on its OVERSAMPLE-th tick.
            if (tick) begin
                if (tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
                    tick_cnt_n = '0;
                    bit_end    = 1'b1;
                end else begin
                    tick_cnt_n = tick_cnt + TICK_W'(1);
                end
            end

            if (bit_end) begin
                case (state)
                    S_START: begin
                        state_n   = S_DATA;
                        bit_idx_n = '0;
                    end
                    S_DATA: begin
                        shreg_n = {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state_n = S_PARITY;
                        end else begin
                            bit_idx_n = bit_idx + 3'd1;
                        end
                    end
                    S_PARITY: state_n = S_STOP;
`ifdef UART_TX_TWO_STOP_EN
                    S_STOP:   state_n = S_STOP2;
                    S_STOP2: begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
`else
                    S_STOP: begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
`endif
                    default:  state_n = S_IDLE;
                endcase
            end
        end

        // Counters sit at zero whenever the transmitter is (or is about to
        // be) idle, so a fresh accept always starts a full-length start bit.
        if (state_n == S_IDLE || state == S_IDLE) begin
            div_cnt_n  = '0;
            tick_cnt_n = '0;
            bit_idx_n  = '0;
        end

        // TxD is registered, so it is derived from where the FSM is going.
        case (state_n)
            S_START:  txd_n = 1'b0;
            S_DATA:   txd_n = shreg_n[0];
            S_PARITY: txd_n = parity_n;
            default:  txd_n = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            div_lat    <= '0;
            TxD        <= 1'b1;
            Tx_DONE    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state      <= state_n;
            div_cnt    <= div_cnt_n;
            tick_cnt   <= tick_cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            parity_bit <= parity_n;
            div_lat    <= div_lat_n;
            TxD        <= txd_n;
            Tx_DONE    <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
//
// Self-checking bench for uart_transmitter. A line monitor decodes every
// frame from TxD and compares it against bytes pushed to a scoreboard queue
// when writes are issued; directed steps check reset, latency, back-to-back
// writes, ignored writes and aborts. Follows UART_TX_TWO_STOP_EN.
// ---------------------------------------------------------------------------
module tb_uart_transmitter;

`ifdef UART_TX_TWO_STOP_EN
    localparam int NBITS = 12;
`else
    localparam int NBITS = 11;
`endif
    localparam int TIMEOUT = 30000;

    logic       clk         = 1'b0;
    logic       reset       = 1'b0;
    logic [2:0] baud_select = 3'b111;
    logic       Tx_EN       = 1'b1;
    logic       Tx_WR       = 1'b0;
    logic [7:0] Tx_DATA     = 8'h00;
    logic       TxD;
    logic       Tx_BUSY;
    logic       Tx_DONE;

    int n_tests        = 0;
    int n_fail         = 0;
    int bit_clks       = 16 * 27;
    int cyc            = 0;
    int t_accept       = 0;
    int frames_done    = 0;
    int frames_aborted = 0;
    logic [7:0] exp_q[$];

    uart_transmitter dut (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .Tx_EN       (Tx_EN),
        .Tx_WR       (Tx_WR),
        .Tx_DATA     (Tx_DATA),
        .TxD         (TxD),
        .Tx_BUSY     (Tx_BUSY),
        .Tx_DONE     (Tx_DONE)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one write strobe; returns at the negedge after the sampling edge.
    task automatic write(input logic [7:0] d, input bit expect_accept);
        @(negedge clk);
        Tx_DATA = d;
        Tx_WR   = 1'b1;
        if (expect_accept) exp_q.push_back(d);
        @(negedge clk);
        Tx_WR = 1'b0;
        if (expect_accept) t_accept = cyc;
    endtask

    // Wait (bounded) for Tx_DONE and check its latency from the accept edge.
    task automatic wait_done(input string tag);
        while (Tx_DONE !== 1'b1 && (cyc - t_accept) < TIMEOUT) @(negedge clk);
        check({tag, "_latency"}, cyc - t_accept, NBITS * bit_clks);
        check({tag, "_busy_at_done"}, Tx_BUSY, 1'b0);
        check({tag, "_txd_at_done"}, TxD, 1'b1);
    endtask

    // Line monitor: decodes frames mid-bit, checks bit stability and length.
    initial begin : monitor
        logic        active;
        int          cnt;
        int          glitch;
        logic        lvl;
        logic [11:0] bits;
        logic [7:0]  d;
        logic [11:0] exp_frame;
        active = 1'b0;
        cnt    = 0;
        glitch = 0;
        lvl    = 1'b1;
        bits   = '1;
        forever begin
            @(negedge clk);
            if (!active && Tx_BUSY === 1'b1 && TxD === 1'b0) begin
                active = 1'b1;
                cnt    = 0;
                glitch = 0;
                bits   = '1;
            end
            if (active) begin
                if (Tx_BUSY === 1'b1) begin
                    if (cnt % bit_clks == 0) lvl = TxD;
                    else if (TxD !== lvl) glitch++;
                    if (cnt % bit_clks == bit_clks / 2 && cnt / bit_clks < 12)
                        bits[cnt / bit_clks] = TxD;
                    cnt++;
                end else if (Tx_DONE === 1'b1) begin
                    active = 1'b0;
                    frames_done++;
                    check("frame_q_nonempty", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        d = exp_q.pop_front();
                        exp_frame = {1'b1, 1'b1, ^d, d, 1'b0};
                        check("frame_bits", bits, exp_frame);
                        check("frame_len", cnt, NBITS * bit_clks);
                        check("frame_glitch", glitch, 0);
                    end
                end else begin
                    // Aborted by reset or Tx_EN=0: drop its scoreboard entry.
                    active = 1'b0;
                    frames_aborted++;
                    check("abort_q_nonempty", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) d = exp_q.pop_front();
                end
            end
        end
    end

    initial begin : stimulus
        int dones;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd", TxD, 1'b1);
        check("rst_busy", Tx_BUSY, 1'b0);
        check("rst_done", Tx_DONE, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", Tx_BUSY, 1'b0);
        check("idle_txd", TxD, 1'b1);

        // Asynchronous reset mid-frame
        write(8'h5A, 1'b1);
        check("t1_start_txd", TxD, 1'b0);
        check("t1_start_busy", Tx_BUSY, 1'b1);
        repeat (3 * bit_clks) @(negedge clk);
        #3 reset = 1'b0;
        #1;
        check("t1_async_txd", TxD, 1'b1);
        check("t1_async_busy", Tx_BUSY, 1'b0);
        check("t1_async_done", Tx_DONE, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t1_post_busy", Tx_BUSY, 1'b0);
        check("t1_post_txd", TxD, 1'b1);
        check("t1_aborted", frames_aborted, 1);

        // 0xA5 at 115200 baud
        write(8'hA5, 1'b1);
        check("t2_start_txd", TxD, 1'b0);
        check("t2_start_busy", Tx_BUSY, 1'b1);
        wait_done("t2");
        @(negedge clk);
        check("t2_done_pulse", Tx_DONE, 1'b0);

        // 0x07 (odd weight), ignored write and baud change while busy
        write(8'h07, 1'b1);
        repeat (2 * bit_clks) @(negedge clk);
        baud_select = 3'b000;
        write(8'h12, 1'b0);
        check("t3_busy_after_ignored", Tx_BUSY, 1'b1);
        wait_done("t3");
        baud_select = 3'b111;

        // Back-to-back: second write in the Tx_DONE cycle
        write(8'h3C, 1'b1);
        wait_done("t4a");
        Tx_DATA = 8'hC3;
        Tx_WR   = 1'b1;
        exp_q.push_back(8'hC3);
        @(negedge clk);
        Tx_WR    = 1'b0;
        t_accept = cyc;
        check("t4_b2b_txd", TxD, 1'b0);
        check("t4_b2b_busy", Tx_BUSY, 1'b1);
        check("t4_b2b_done_low", Tx_DONE, 1'b0);
        wait_done("t4b");

        // Abort with Tx_EN=0 during D3 of 0xFF
        write(8'hFF, 1'b1);
        repeat (4 * bit_clks + bit_clks / 2 - 1) @(negedge clk);
        check("t5_d3_busy", Tx_BUSY, 1'b1);
        Tx_EN = 1'b0;
        @(negedge clk);
        check("t5_abort_txd", TxD, 1'b1);
        check("t5_abort_busy", Tx_BUSY, 1'b0);
        check("t5_abort_done", Tx_DONE, 1'b0);
        dones = 0;
        for (int i = 0; i < 2 * bit_clks; i++) begin
            @(negedge clk);
            if (Tx_DONE === 1'b1) dones++;
        end
        check("t5_no_done", dones, 0);
        write(8'h66, 1'b0);
        @(negedge clk);
        check("t5_disabled_write_busy", Tx_BUSY, 1'b0);
        check("t5_aborted", frames_aborted, 2);
        Tx_EN = 1'b1;
        write(8'h81, 1'b1);
        check("t5_restart_txd", TxD, 1'b0);
        wait_done("t5");

        // 0x55 at baud code 110
        baud_select = 3'b110;
        bit_clks    = 16 * 54;
        write(8'h55, 1'b1);
        wait_done("t6");

        repeat (4) @(negedge clk);
        check("end_queue_empty", exp_q.size(), 0);
        check("end_frames_done", frames_done, 6);
        check("end_frames_aborted", frames_aborted, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
